// File: rtl/isa_pkg.sv
// Shared ISA definitions for the 16-bit-instruction / 8-bit-data control path:
// opcode and sequencer state encodings, instruction field positions, strobe bundle.
package isa_pkg;

   localparam int OPC_MSB = 15;
   localparam int OPC_LSB = 13;
   localparam int IMM_BIT = 12;

   typedef enum logic [2:0] {
      ST  = 3'b000,
      LD  = 3'b001,
      ADD = 3'b010,
      SUB = 3'b011,
      BEQ = 3'b100,
      LDI = 3'b101,
      HLT = 3'b110,
      NOP = 3'b111
   } opcode_e;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      EXEC,
      MEM,
      HALT,
      FAULT
   } state_e;

   typedef struct packed {
      logic reg_write;
      logic mem_to_reg;
      logic alu_f;
      logic addition;
      logic branch;
      logic mem_write;
   } ctrl_t;

   function automatic opcode_e get_opcode(input logic [15:0] instr);
      return opcode_e'(instr[OPC_MSB:OPC_LSB]);
   endfunction

endpackage

// File: rtl/instr_decoder.sv
// Pure combinational opcode -> datapath strobe decode; the sequencer decides
// in which cycles these strobes are actually allowed onto the datapath.
module instr_decoder
   import isa_pkg::*;
(
   input  opcode_e opcode,
   output ctrl_t   ctrl
);

   always_comb begin
      ctrl = '0;
      case (opcode)
         ST:  ctrl.mem_write = 1'b1;
         LD:  ctrl.mem_to_reg = 1'b1;
         ADD: begin
            ctrl.reg_write = 1'b1;
            ctrl.addition  = 1'b1;
         end
         SUB: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_f     = 1'b1;
         end
         BEQ: begin
            ctrl.branch = 1'b1;
            ctrl.alu_f  = 1'b1;
         end
         LDI: ctrl.reg_write = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle sequencer: owns the PC, fetches over a handshaked instruction port,
// drives decoded strobes during EXEC/MEM and handles halt, single-step and timeouts.
module instr_sequencer
   import isa_pkg::*;
#(
   parameter int ADDR_W   = 5,
   parameter int INSTR_W  = 16,
   parameter int TIMEOUT  = 15,
   parameter int RESET_PC = 0,
   parameter int CNT_W    = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               run,
   input  logic               step,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_data,
   output logic [INSTR_W-1:0] instruction,
   output logic [ADDR_W-1:0]  currentInstructionAddress,
   input  logic [ADDR_W-1:0]  nextInstructionAddress,
   output logic               dmem_req,
   input  logic               dmem_ack,
   output logic               regWrite,
   output logic               memToReg,
   output logic               aluF,
   output logic               addition,
   output logic               branch,
   output logic               memWrite,
   output logic               halted,
   output logic               fault,
   output logic [CNT_W-1:0]   retired
);

   localparam int WAIT_W = $clog2(TIMEOUT + 1);
   localparam logic [ADDR_W-1:0] PC_INIT   = ADDR_W'(RESET_PC);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   state_e            state;
   logic [ADDR_W-1:0] pc;
   logic [WAIT_W-1:0] wait_cnt;
   logic              run_q;
   opcode_e           opcode;
   ctrl_t             ctrl;

   assign opcode = get_opcode(instruction[OPC_MSB:0]);

   instr_decoder u_decoder (
      .opcode (opcode),
      .ctrl   (ctrl)
   );

   // Leaving HALT resets the PC, so IDLE never needs to know where it came from.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         pc          <= PC_INIT;
         instruction <= '0;
         retired     <= '0;
         wait_cnt    <= '0;
         run_q       <= 1'b0;
      end else begin
         run_q <= run;
         case (state)
            IDLE: begin
               if (run || step) begin
                  state    <= FETCH;
                  wait_cnt <= '0;
               end
            end
            FETCH: begin
               if (imem_ack) begin
                  instruction <= imem_data;
                  state       <= EXEC;
               end else if (wait_cnt == WAIT_LAST) begin
                  state <= FAULT;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            EXEC: begin
               wait_cnt <= '0;
               case (opcode)
                  ST, LD: state <= MEM;
                  HLT:    state <= HALT;
                  default: begin
                     pc      <= nextInstructionAddress;
                     retired <= retired + 1'b1;
                     state   <= run ? FETCH : IDLE;
                  end
               endcase
            end
            MEM: begin
               if (dmem_ack) begin
                  pc       <= nextInstructionAddress;
                  retired  <= retired + 1'b1;
                  wait_cnt <= '0;
                  state    <= run ? FETCH : IDLE;
               end else if (wait_cnt == WAIT_LAST) begin
                  state <= FAULT;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            HALT: begin
               if (run && !run_q) begin
                  state <= IDLE;
                  pc    <= PC_INIT;
               end
            end
            FAULT: ;
            default: state <= IDLE;
         endcase
      end
   end

   // Memory strobes belong to MEM only; a load writes back in its ack cycle.
   always_comb begin
      regWrite = 1'b0;
      memToReg = 1'b0;
      aluF     = 1'b0;
      addition = 1'b0;
      branch   = 1'b0;
      memWrite = 1'b0;
      case (state)
         EXEC: begin
            regWrite = ctrl.reg_write;
            aluF     = ctrl.alu_f;
            addition = ctrl.addition;
            branch   = ctrl.branch;
         end
         MEM: begin
            memWrite = ctrl.mem_write;
            memToReg = ctrl.mem_to_reg;
            regWrite = ctrl.mem_to_reg & dmem_ack;
         end
         default: ;
      endcase
   end

   assign imem_req                  = (state == FETCH);
   assign dmem_req                  = (state == MEM);
   assign halted                    = (state == HALT);
   assign fault                     = (state == FAULT);
   assign imem_addr                 = pc;
   assign currentInstructionAddress = pc;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios plus randomized
// programs checked against an instruction-level reference model.
module tb_instr_sequencer;

   localparam logic [2:0] OP_ST  = 3'd0;
   localparam logic [2:0] OP_LD  = 3'd1;
   localparam logic [2:0] OP_ADD = 3'd2;
   localparam logic [2:0] OP_SUB = 3'd3;
   localparam logic [2:0] OP_BEQ = 3'd4;
   localparam logic [2:0] OP_LDI = 3'd5;
   localparam logic [2:0] OP_HLT = 3'd6;
   localparam logic [2:0] OP_NOP = 3'd7;

   logic        clk = 1'b0;
   logic        reset;
   logic        run;
   logic        step;
   logic        imem_req;
   logic [4:0]  imem_addr;
   logic        imem_ack;
   logic [15:0] imem_data;
   logic [15:0] instruction;
   logic [4:0]  currentInstructionAddress;
   logic [4:0]  nextInstructionAddress;
   logic        dmem_req;
   logic        dmem_ack;
   logic        regWrite, memToReg, aluF, addition, branch, memWrite;
   logic        halted;
   logic        fault;
   logic [7:0]  retired;

   logic [15:0] prog [32];
   logic [4:0]  br_tgt [32];
   logic [4:0]  exp_pc;
   logic [7:0]  exp_retired;
   logic [2:0]  last_opc;
   int          fetch_lo, fetch_hi, mem_lo, mem_hi;
   int          tests = 0;
   int          failed = 0;
   int          rw_count = 0;
   logic [5:0]  strobes;

   assign strobes = {regWrite, memToReg, aluF, addition, branch, memWrite};

   always #5 clk = ~clk;

   instr_sequencer dut (
      .clk                       (clk),
      .reset                     (reset),
      .run                       (run),
      .step                      (step),
      .imem_req                  (imem_req),
      .imem_addr                 (imem_addr),
      .imem_ack                  (imem_ack),
      .imem_data                 (imem_data),
      .instruction               (instruction),
      .currentInstructionAddress (currentInstructionAddress),
      .nextInstructionAddress    (nextInstructionAddress),
      .dmem_req                  (dmem_req),
      .dmem_ack                  (dmem_ack),
      .regWrite                  (regWrite),
      .memToReg                  (memToReg),
      .aluF                      (aluF),
      .addition                  (addition),
      .branch                    (branch),
      .memWrite                  (memWrite),
      .halted                    (halted),
      .fault                     (fault),
      .retired                   (retired)
   );

   // Datapath stand-in: branches jump to a per-address target, everything else falls through.
   always_comb begin
      if (instruction[15:13] == OP_BEQ)
         nextInstructionAddress = br_tgt[currentInstructionAddress];
      else
         nextInstructionAddress = currentInstructionAddress + 5'd1;
   end

   always @(negedge clk) rw_count <= rw_count + int'(regWrite);

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      tests++;
      if (observed !== expected) begin
         failed++;
         $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Expected strobe vector {regWrite,memToReg,aluF,addition,branch,memWrite}.
   function automatic logic [5:0] expStrobes(input logic [2:0] opc, input logic in_mem,
                                             input logic ack);
      logic [5:0] s;
      s = 6'b0;
      if (!in_mem) begin
         case (opc)
            OP_ADD: s = 6'b100100;
            OP_SUB: s = 6'b101000;
            OP_BEQ: s = 6'b001010;
            OP_LDI: s = 6'b100000;
            default: s = 6'b0;
         endcase
      end else begin
         if (opc == OP_ST) s = 6'b000001;
         if (opc == OP_LD) s = {ack, 1'b1, 4'b0000};
      end
      return s;
   endfunction

   function automatic logic [15:0] mkInstr(input logic [2:0] opc);
      logic [12:0] low;
      low = 13'($urandom);
      return {opc, low};
   endfunction

   task automatic applyStimulus_reset();
      reset     = 1'b0;
      run       = 1'b0;
      step      = 1'b0;
      imem_ack  = 1'b0;
      dmem_ack  = 1'b0;
      imem_data = 16'h0;
      repeat (2) @(negedge clk);
      checkOutput("rst_req", {imem_req, dmem_req, halted, fault}, 4'b0);
      checkOutput("rst_strobes", strobes, 6'b0);
      checkOutput("rst_pc", currentInstructionAddress, 5'd0);
      checkOutput("rst_retired", retired, 8'd0);
      checkOutput("rst_instr", instruction, 16'h0);
      reset = 1'b1;
      @(negedge clk);
      exp_pc      = 5'd0;
      exp_retired = 8'd0;
   endtask

   // Runs one instruction from its first FETCH cycle to the first cycle after it completes.
   task automatic applyStimulus_exec(input logic stop_mid);
      logic [15:0] ins;
      logic [2:0]  opc;
      logic [4:0]  nxt;
      int          d, m;
      ins = prog[exp_pc];
      opc = ins[15:13];
      nxt = (opc == OP_BEQ) ? br_tgt[exp_pc] : exp_pc + 5'd1;
      last_opc = opc;
      checkOutput("fetch_addr", imem_addr, exp_pc);
      d = $urandom_range(fetch_hi, fetch_lo);
      for (int i = 0; i <= d; i++) begin
         if (i > 0) @(negedge clk);
         checkOutput("fetch_req", imem_req, 1'b1);
         checkOutput("fetch_strobes", strobes, 6'b0);
         dmem_ack = 1'($urandom);
         if (i == d) begin
            imem_ack  = 1'b1;
            imem_data = ins;
         end else begin
            imem_ack  = 1'b0;
            imem_data = 16'($urandom);
         end
      end
      @(negedge clk);
      imem_ack  = 1'($urandom);
      imem_data = 16'($urandom);
      dmem_ack  = 1'b0;
      if (stop_mid) run = 1'b0;
      checkOutput("exec_instr", instruction, ins);
      checkOutput("exec_strobes", strobes, expStrobes(opc, 1'b0, 1'b0));
      if (opc == OP_ST || opc == OP_LD) begin
         m = $urandom_range(mem_hi, mem_lo);
         for (int j = 0; j <= m; j++) begin
            @(negedge clk);
            checkOutput("mem_req", dmem_req, 1'b1);
            imem_ack = 1'($urandom);
            dmem_ack = (j == m);
            #1;
            checkOutput("mem_strobes", strobes, expStrobes(opc, 1'b1, j == m));
         end
      end
      @(negedge clk);
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      if (opc == OP_HLT) begin
         checkOutput("halted", halted, 1'b1);
         checkOutput("halt_req", imem_req, 1'b0);
      end else begin
         exp_pc      = nxt;
         exp_retired = exp_retired + 8'd1;
         checkOutput("next_req", imem_req, run);
      end
      checkOutput("pc", currentInstructionAddress, exp_pc);
      checkOutput("retired", retired, exp_retired);
   endtask

   // Leaves the DUT in its first FETCH cycle after a HALT, via a run rising edge.
   task automatic applyStimulus_restart();
      if (run) begin
         run = 1'b0;
         @(negedge clk);
         checkOutput("halt_hold", halted, 1'b1);
      end
      run = 1'b1;
      repeat (2) @(negedge clk);
      exp_pc = 5'd0;
   endtask

   initial begin
      int rw0;
      for (int i = 0; i < 32; i++) begin
         prog[i]   = mkInstr(OP_NOP);
         br_tgt[i] = 5'($urandom);
      end
      fetch_lo = 0; fetch_hi = 0; mem_lo = 0; mem_hi = 0;

      // ADD, ADD, HLT with immediate fetch acks
      applyStimulus_reset();
      prog[0] = mkInstr(OP_ADD);
      prog[1] = mkInstr(OP_ADD);
      prog[2] = mkInstr(OP_HLT);
      rw0 = rw_count;
      run = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 3; k++) applyStimulus_exec(1'b0);
      repeat (2) @(negedge clk);
      checkOutput("add_rw_pulses", rw_count - rw0, 2);
      checkOutput("add_halted", halted, 1'b1);
      checkOutput("add_retired", retired, 8'd2);

      // Load with a three-cycle data-memory delay
      applyStimulus_reset();
      prog[0] = mkInstr(OP_LD);
      prog[1] = mkInstr(OP_HLT);
      mem_lo = 3; mem_hi = 3;
      run = 1'b1;
      @(negedge clk);
      applyStimulus_exec(1'b0);
      applyStimulus_exec(1'b0);
      checkOutput("ld_retired", retired, 8'd1);

      // Fetch never acknowledged
      applyStimulus_reset();
      run = 1'b1;
      @(negedge clk);
      for (int i = 1; i <= 15; i++) begin
         checkOutput("to_wait_req", imem_req, 1'b1);
         checkOutput("to_wait_fault", fault, 1'b0);
         if (i < 15) @(negedge clk);
      end
      @(negedge clk);
      checkOutput("to_fault", fault, 1'b1);
      checkOutput("to_req", {imem_req, dmem_req}, 2'b00);
      checkOutput("to_strobes", strobes, 6'b0);
      imem_ack = 1'b1;
      dmem_ack = 1'b1;
      run = 1'b0;
      @(negedge clk);
      run  = 1'b1;
      step = 1'b1;
      repeat (4) @(negedge clk);
      step = 1'b0;
      checkOutput("to_sticky", {fault, imem_req, halted}, 3'b100);

      // PC wraps from 31 to 0
      applyStimulus_reset();
      prog[0]   = mkInstr(OP_BEQ);
      br_tgt[0] = 5'd31;
      prog[31]  = mkInstr(OP_ADD);
      fetch_lo = 0; fetch_hi = 2; mem_lo = 0; mem_hi = 0;
      run = 1'b1;
      @(negedge clk);
      applyStimulus_exec(1'b0);
      applyStimulus_exec(1'b0);
      applyStimulus_exec(1'b1);
      checkOutput("wrap_idle", imem_req, 1'b0);

      // Single step through SUB, SUB
      applyStimulus_reset();
      prog[0] = mkInstr(OP_SUB);
      prog[1] = mkInstr(OP_SUB);
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      applyStimulus_exec(1'b0);
      repeat (3) @(negedge clk);
      checkOutput("step_idle", {imem_req, halted}, 2'b00);
      checkOutput("step_one", retired, 8'd1);
      checkOutput("step_pc", currentInstructionAddress, 5'd1);
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      applyStimulus_exec(1'b0);
      checkOutput("step_two", retired, 8'd2);

      // Reset during a store's memory phase
      applyStimulus_reset();
      prog[0] = mkInstr(OP_ST);
      run = 1'b1;
      @(negedge clk);
      imem_ack  = 1'b1;
      imem_data = prog[0];
      @(negedge clk);
      imem_ack = 1'b0;
      @(negedge clk);
      checkOutput("st_mem", {dmem_req, memWrite}, 2'b11);
      #2 reset = 1'b0;
      #1;
      checkOutput("st_async", {dmem_req, memWrite}, 2'b00);
      dmem_ack = 1'b1;
      run = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      dmem_ack = 1'b0;
      checkOutput("st_after", {imem_req, dmem_req, halted, fault}, 4'b0);
      checkOutput("st_pc", currentInstructionAddress, 5'd0);
      checkOutput("st_retired", retired, 8'd0);

      // Randomized programs with random latencies, stops and halts
      applyStimulus_reset();
      for (int i = 0; i < 32; i++) begin
         logic [2:0] o;
         o = 3'($urandom);
         if (o == OP_HLT && ($urandom_range(3, 0) != 0)) o = OP_LDI;
         prog[i]   = mkInstr(o);
         br_tgt[i] = 5'($urandom);
      end
      fetch_lo = 0; fetch_hi = 4; mem_lo = 0; mem_hi = 4;
      run = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 80; k++) begin
         logic stop;
         stop = ($urandom_range(7, 0) == 0);
         applyStimulus_exec(stop);
         if (last_opc == OP_HLT) begin
            applyStimulus_restart();
         end else if (stop) begin
            @(negedge clk);
            checkOutput("rand_idle", imem_req, 1'b0);
            run = 1'b1;
            @(negedge clk);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
